// File: rtl/moore_seq_pkg.sv
// Shared types and constants for the Moore serial sequence detector.
// Holds the reset-default pattern, the overlap-mode enum and the length-clamp helper.
package moore_seq_pkg;

    localparam logic [7:0] DEF_PATTERN_C = 8'b0000_0001;
    localparam int         DEF_LEN_C     = 3;
    localparam bit         DEF_OVERLAP_C = 1'b1;

    typedef enum logic {
        SEQ_NONOVL = 1'b0,
        SEQ_OVL    = 1'b1
    } seq_mode_e;

    // A length of 0 means 1; anything above the history depth means the full depth.
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 1) begin
            return 1;
        end
        if (len > pat_w) begin
            return pat_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// sat is registered and rises on the same edge the count reaches all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc && !r_sat) begin
            r_count <= w_count_inc;
            r_sat   <= &w_count_inc;
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/moore_seq_detector.sv
// Runtime-programmable serial pattern detector with registered one-cycle det pulse.
// Define MOORE_SEQ_DET_COUNT_EN to build the saturating match counter.
module moore_seq_detector
    import moore_seq_pkg::*;
#(
    parameter int                 PAT_W       = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [PAT_W-1:0]   DEF_PATTERN = PAT_W'(DEF_PATTERN_C),
    parameter int                 DEF_LEN     = DEF_LEN_C,
    parameter bit                 DEF_OVERLAP = DEF_OVERLAP_C,
    localparam int                LEN_W       = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    seq_mode_e        r_ovl;
    logic             r_det;

    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [PAT_W-1:0] w_len_mask;
    logic             w_match;
    logic             w_det_next;
    logic             w_unused_hist_msb;

    assign w_hist_next       = {r_hist[PAT_W-2:0], inp};
    assign w_fill_next       = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    assign w_unused_hist_msb = r_hist[PAT_W-1];

    // Only the low len bits of history and pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign w_len_mask[gi] = (LEN_W'(gi) < r_len);
        end
    endgenerate

    assign w_match    = (w_fill_next >= r_len) &&
                        (((w_hist_next ^ r_pat) & w_len_mask) == '0);
    assign w_det_next = in_valid && !cfg_load && w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PATTERN;
            r_len  <= LEN_W'(clamp_len(DEF_LEN, PAT_W));
            r_ovl  <= seq_mode_e'(DEF_OVERLAP);
            r_det  <= 1'b0;
        end else if (cfg_load) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= cfg_pattern;
            r_len  <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            r_ovl  <= seq_mode_e'(cfg_overlap);
            r_det  <= 1'b0;
        end else begin
            r_det <= w_det_next;
            if (in_valid) begin
                r_hist <= w_hist_next;
                // Non-overlapping mode demands len fresh bits before the next match.
                r_fill <= (w_match && r_ovl == SEQ_NONOVL) ? '0 : w_fill_next;
            end
        end
    end

    assign det = r_det;

`ifdef MOORE_SEQ_DET_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_det_next),
        .clr   (cnt_clr),
        .count (match_count),
        .sat   (cnt_sat)
    );
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_count      = '0;
    assign cnt_sat          = 1'b0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Self-checking bench for moore_seq_detector: directed tables plus randomized stream
// against a queue-based reference model; a second instance uses a 2-bit counter.
module tb_moore_seq_detector;
    import moore_seq_pkg::*;

    localparam int PAT_W  = 8;
    localparam int CNT_W  = 16;
    localparam int SCNT_W = 2;
    localparam int LEN_W  = $clog2(PAT_W + 1);
`ifdef MOORE_SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, inp, in_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [PAT_W-1:0]  cfg_pattern;
    logic [LEN_W-1:0]  cfg_len;
    logic              det, cnt_sat, det_s, cnt_sat_s;
    logic [CNT_W-1:0]  match_count;
    logic [SCNT_W-1:0] match_count_s;

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .det(det), .match_count(match_count), .cnt_sat(cnt_sat));

    moore_seq_detector #(.PAT_W(PAT_W), .CNT_W(SCNT_W)) dut_s (
        .clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .det(det_s), .match_count(match_count_s), .cnt_sat(cnt_sat_s));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the accepted bits since the last clear, oldest first.
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_det;
    longint           m_cnt, m_cnt_s;
    localparam longint MAX_L = (longint'(1) << CNT_W) - 1;
    localparam longint MAX_S = (longint'(1) << SCNT_W) - 1;

    function automatic void model_step();
        bit match;
        if (reset) begin
            m_q.delete();
            m_pat = PAT_W'(DEF_PATTERN_C);
            m_len = DEF_LEN_C;
            m_ovl = DEF_OVERLAP_C;
            m_det = 1'b0;
            m_cnt = 0;
            m_cnt_s = 0;
            return;
        end
        m_det = 1'b0;
        if (cfg_load) begin
            m_q.delete();
            m_pat = cfg_pattern;
            m_len = clamp_len(int'(cfg_len), PAT_W);
            m_ovl = cfg_overlap;
        end else if (in_valid) begin
            m_q.push_back(inp);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            match = (m_q.size() >= m_len);
            for (int k = 0; k < m_len && match; k++)
                if (m_q[m_q.size() - 1 - k] != m_pat[k]) match = 1'b0;
            m_det = match;
            if (match && !m_ovl) m_q.delete();
        end
        if (cnt_clr) begin
            m_cnt = 0;
            m_cnt_s = 0;
        end else if (m_det) begin
            if (m_cnt < MAX_L) m_cnt++;
            if (m_cnt_s < MAX_S) m_cnt_s++;
        end
        if (!CNT_ON) begin
            m_cnt = 0;
            m_cnt_s = 0;
        end
    endfunction

    task automatic expect_val(string name, longint act, longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model(string tag);
        expect_val({tag, " det"}, longint'(det), longint'(m_det));
        expect_val({tag, " count"}, longint'(match_count), m_cnt);
        expect_val({tag, " sat"}, longint'(cnt_sat), longint'(m_cnt == MAX_L));
        expect_val({tag, " det_s"}, longint'(det_s), longint'(m_det));
        expect_val({tag, " count_s"}, longint'(match_count_s), m_cnt_s);
        expect_val({tag, " sat_s"}, longint'(cnt_sat_s), longint'(CNT_ON && m_cnt_s == MAX_S));
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic load_cfg(logic [PAT_W-1:0] p, int l, bit o, bit clr, bit v, bit b, string tag);
        reset = 0; cfg_load = 1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o;
        cnt_clr = clr; in_valid = v; inp = b;
        tick(tag);
        cfg_load = 0; cnt_clr = 0; in_valid = 0;
    endtask

    typedef struct { bit valid; bit b; bit exp_det; } vec_t;
    vec_t tbl[$];

    task automatic run_table(string tag);
        foreach (tbl[i]) begin
            reset = 0; cfg_load = 0; cnt_clr = 0;
            in_valid = tbl[i].valid; inp = tbl[i].b;
            tick(tag);
            expect_val({tag, " table det"}, longint'(det), longint'(tbl[i].exp_det));
            $display("%s vec %0d: valid=%0b inp=%0b det=%0b count=%0d", tag, i, tbl[i].valid, tbl[i].b, det, match_count);
        end
        tbl.delete();
        in_valid = 0;
    endtask

    task automatic add(bit v, bit b, bit e);
        vec_t t;
        t.valid = v; t.b = b; t.exp_det = e;
        tbl.push_back(t);
    endtask

    initial begin
        reset = 1; inp = 0; in_valid = 0; cfg_load = 0; cfg_overlap = 0; cnt_clr = 0;
        cfg_pattern = '0; cfg_len = '0;
        tick("reset");
        tick("reset");
        expect_val("reset det", longint'(det), 0);
        expect_val("reset count", longint'(match_count), 0);
        expect_val("reset sat", longint'(cnt_sat), 0);
        reset = 0;

        // Default pattern "001", overlap on.
        add(1,1,0); add(1,0,0); add(1,0,0); add(1,1,1); add(1,0,0); add(1,0,0); add(1,1,1);
        run_table("default");
        expect_val("default count", longint'(match_count), CNT_ON ? 2 : 0);

        // "11" overlapping then non-overlapping.
        load_cfg(8'b11, 2, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_ovl");
        add(1,1,0); add(1,1,1); add(1,1,1); add(1,1,1);
        run_table("ovl");
        expect_val("ovl count", longint'(match_count), CNT_ON ? 3 : 0);
        expect_val("ovl sat_s", longint'(cnt_sat_s), CNT_ON ? 1 : 0);
        load_cfg(8'b11, 2, 1'b0, 1'b1, 1'b0, 1'b0, "cfg_nonovl");
        add(1,1,0); add(1,1,1); add(1,1,0); add(1,1,1);
        run_table("nonovl");
        expect_val("nonovl count", longint'(match_count), CNT_ON ? 2 : 0);

        // "101" with three idle cycles between accepts.
        load_cfg(8'b101, 3, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_gap");
        add(1,1,0); add(0,1,0); add(0,0,0); add(0,1,0);
        add(1,0,0); add(0,1,0); add(0,1,0); add(0,0,0);
        add(1,1,1); add(0,1,0);
        run_table("gap");

        // Mid-stream reload with a valid bit in the load cycle: that bit is dropped.
        add(1,1,0); add(1,0,0);
        run_table("mid_pre");
        load_cfg(8'b0110, 4, 1'b1, 1'b0, 1'b1, 1'b1, "cfg_mid");
        expect_val("mid load det", longint'(det), 0);
        add(1,0,0); add(1,1,0); add(1,1,0); add(1,0,1);
        run_table("mid");

        // Length 0 clamps to 1; length 15 clamps to 8.
        load_cfg(8'h01, 0, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_len0");
        add(1,1,1); add(1,1,1); add(1,0,0); add(1,1,1);
        run_table("len0");
        load_cfg(8'b1011_0010, 15, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_len15");
        add(1,1,0); add(1,0,0); add(1,1,0); add(1,1,0);
        add(1,0,0); add(1,0,0); add(1,1,0); add(1,0,1);
        run_table("len15");

        // Saturation of the 2-bit counter, then clear colliding with a match.
        load_cfg(8'h01, 1, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_sat");
        for (int i = 0; i < 5; i++) add(1,1,1);
        run_table("sat");
        expect_val("sat count_s", longint'(match_count_s), CNT_ON ? 3 : 0);
        expect_val("sat flag_s", longint'(cnt_sat_s), CNT_ON ? 1 : 0);
        expect_val("sat count", longint'(match_count), CNT_ON ? 5 : 0);
        in_valid = 1; inp = 1; cnt_clr = 1;
        tick("clr_match");
        expect_val("clr_match det", longint'(det), 1);
        expect_val("clr_match count", longint'(match_count), 0);
        expect_val("clr_match count_s", longint'(match_count_s), 0);
        cnt_clr = 0; in_valid = 0;

        // Reset mid-stream discards the partial match.
        load_cfg(8'b11, 2, 1'b1, 1'b0, 1'b1, 1'b1, "cfg_rst");
        in_valid = 1; inp = 1;
        tick("rst_pre");
        reset = 1;
        tick("rst_mid");
        reset = 0;

        // Randomized stream against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 399) == 0);
            cfg_load    = ($urandom_range(0, 49) == 0);
            cfg_pattern = PAT_W'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 3));
            cfg_overlap = 1'($urandom);
            cnt_clr     = ($urandom_range(0, 99) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            inp         = 1'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised Moore-style serial sequence detector, the generalised successor to the fixed 3-bit "001" detector. It matches a runtime-programmable pattern of 1 to PAT_W bits on a qualified serial input. Overlapping or non-overlapping matching is selectable, and matches are counted in a saturating counter. It sits on serial bit streams (framing and sync-word detection) and drives a registered one-cycle `det` pulse to downstream control.

## Interface
- `PAT_W`, 8: maximum pattern length in bits, ≥ 2.
- `CNT_W`, 16: match counter width.
- `DEF_PATTERN`, 8'b0000_0001: pattern after reset. The low DEF_LEN bits are used.
- `DEF_LEN`, 3: pattern length after reset, 1..PAT_W.
- `DEF_OVERLAP`, 1: overlap mode after reset.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `inp` in 1: serial data bit.
- `in_valid` in 1: `inp` is sampled only in cycles where this is high.
- `cfg_load` in 1: one-cycle strobe that loads the pattern, length and mode.
- `cfg_pattern` in PAT_W: pattern. Bit [len-1] is the oldest bit and bit [0] is the most recent bit.
- `cfg_len` in $clog2(PAT_W+1): pattern length.
- `cfg_overlap` in 1: 1 = overlapping matches allowed, 0 = non-overlapping.
- `cnt_clr` in 1: clears the match counter.
- `det` out 1: registered match pulse.
- `match_count` out CNT_W: number of matches, saturating.
- `cnt_sat` out 1: high while `match_count` is at its all-ones value.

## Operation
- **State registers:**
  - `hist[PAT_W-1:0]`: shift history, with the newest bit in `hist[0]`.
  - `fill`: count of valid bits since the last clear, saturating at PAT_W.
  - `pat`, `len`, `ovl`: the active configuration.
  - `det`: match flag.
  - `match_count`: match counter.
- **Accept cycle** (`in_valid=1`, `cfg_load=0`):
  - `hist <= {hist[PAT_W-2:0], inp}`.
  - `fill` increments, saturating at PAT_W.
- **Match condition** (evaluated on the shifted history): `fill_next ≥ len` AND `hist_next[len-1:0] == pat[len-1:0]`.
- **det:** `det <= accept & match`. It depends only on registered state and never combinationally on `inp`.
- **On a match:**
  - If `ovl=0`, `fill <= 0`. The next match then needs `len` fresh bits.
  - If `ovl=1`, `fill` continues normally.
- **Length clamping:** `cfg_len` of 0 is loaded as 1, and `cfg_len` greater than PAT_W is loaded as PAT_W.
- **cfg_load:**
  - Loads `pat`, the clamped `len` and `ovl`.
  - Clears `hist`, `fill` and `det`.
  - `inp` in that cycle is dropped, even if `in_valid=1`.
  - `match_count` is unaffected.
- **Counter:** `match_count` increments on each cycle where `det` is set (same edge as `det`). It holds at the all-ones value and never wraps.
- **cnt_clr:** sets `match_count` to 0. If a match occurs in the same cycle, clear wins and the count is 0.
- **Reset values:**
  - `det=0`, `match_count=0`, `cnt_sat=0`, `hist=0`, `fill=0`.
  - `pat=DEF_PATTERN`, `len=DEF_LEN`, `ovl=DEF_OVERLAP`.
  - Reset asserted mid-stream discards any partial match.

## Timing
- **Latency:** `det` is high in cycle N+1 when the bit accepted in cycle N completes the pattern.
- **Pulse width:**
  - `det` is high for exactly one cycle per match.
  - Back-to-back accepts can give consecutive `det` cycles (e.g. len=1, or pattern "11" in overlap mode).
  - A cycle with `in_valid=0` always gives `det=0` in the next cycle and leaves `hist` and `fill` unchanged.
- **Config:** takes effect on the edge where `cfg_load` is sampled. The first match is possible no earlier than `len` accepts later.
- **cnt_sat:** registered, and asserts on the same edge that `match_count` reaches its maximum.

## Configuration
- **`MOORE_SEQ_DET_COUNT_EN` defined:** the match counter, `cnt_clr` handling and `cnt_sat` are built as specified above.
- **Not defined:**
  - `match_count` is tied to 0, `cnt_sat` is tied to 0 and `cnt_clr` is ignored.
  - Detection behaviour and `det` timing are identical in both builds.

## Structure
- **Package `moore_seq_pkg`:**
  - Default-pattern constants.
  - Overlap-mode enum (`SEQ_NONOVL`, `SEQ_OVL`).
  - A length-clamp function shared with the bench.
- **Sub-module `sat_counter`:**
  - Parameter CNT_W.
  - Ports: `inc`, `clr` (clr priority), `count`, `sat`.
  - Instantiated only under `MOORE_SEQ_DET_COUNT_EN`.

## Test plan
- **Reset defaults:** pattern "001" len 3; stream 1,0,0,1,0,0,1 with `in_valid` high → `det` high the cycle after bits 4 and 7; `match_count=2`.
- **Overlap vs non-overlap:** pattern "11" len 2; stream 1,1,1,1:
  - overlap → 3 `det` pulses, `match_count=3`;
  - non-overlap → pulses after bits 2 and 4 only, `match_count=2`.
- **Gapped valid:** pattern "101"; bits 1,0,1 with `in_valid` low for 3 cycles between each bit → a single `det` one cycle after the third accept; no `det` in the gap cycles.
- **Config mid-stream:** after accepting 1,0, pulse `cfg_load` with `inp`=1 and `in_valid`=1 in the same cycle, loading pattern "0110" len 4 → the bit is dropped and no `det`; then 0,1,1,0 → `det` after the 4th bit.
- **Length clamp:** `cfg_len=0`, `pat[0]=1`; stream 1,1,0,1 → 3 `det` pulses. `cfg_len=15` with PAT_W=8 → `len` reads as 8.
- **Counter:** CNT_W=2; 5 matches → count sticks at 3 and `cnt_sat=1`. `cnt_clr` in the same cycle as a match → `match_count=0`. Build without the macro → `match_count` stays 0 and `det` is unchanged.
